// File: rtl/dendy_pkg.sv
// Shared constants for the Dendy memory subsystem: default bus widths,
// requester channel numbering and an index-width helper.
package dendy_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 15;

    localparam int CH_PPU = 0;
    localparam int CH_OAM = 1;
    localparam int CH_CPU = 2;
    localparam int CH_DBG = 3;

    // Bits needed to index n items; never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dendy_rr_pick.sv
// Round-robin picker: rotates the request mask so the search starts at the
// pointer, takes the lowest set bit, and maps it back to a channel one-hot.
module dendy_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [N-1:0]  rot;
    logic [PW-1:0] k;

    always_comb begin
        rot   = '0;
        k     = '0;
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            k      = PW'((i + int'(start)) % N);
            rot[i] = mask[k];
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && rot[i]) begin
                valid = 1'b1;
                k     = PW'((i + int'(start)) % N);
                grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dendy_mem_arbiter.sv
// N-channel arbiter sharing one single-port synchronous RAM: fixed priority
// for PRIO_CH with a starvation guard, round-robin otherwise, pipelined reads.
module dendy_mem_arbiter
    import dendy_pkg::*;
#(
    parameter int CH      = 4,
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int PRIO_CH = CH_PPU,
    parameter int STARVE  = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [CH-1:0]   req,
    input  logic [CH-1:0]   we,
    input  logic [CH*AW-1:0] addr,
    input  logic [CH*DW-1:0] wdata,
    output logic [CH-1:0]   ack,
    output logic [DW-1:0]   rdata,
    output logic [CH-1:0]   rvalid,
    output logic [AW-1:0]   mem_a,
    output logic [DW-1:0]   mem_o,
    output logic            mem_w,
    input  logic [DW-1:0]   mem_i
);

    localparam int PW = idx_w(CH);
    localparam logic [CH-1:0] PRIO_BIT =
        (PRIO_CH < CH) ? ({{(CH-1){1'b0}}, 1'b1} << PRIO_CH) : '0;

    logic [PW-1:0] rr_ptr, ptr_nxt;
    logic [3:0]    starve_cnt, starve_nxt;
    logic [CH-1:0] elig, np_req, np_elig;
    logic [CH-1:0] g_all, g_np, win;
    logic          v_all, v_np, use_rr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_we;
    logic [CH-1:0] rd_tag_p0, rd_tag_p1;

    // A channel whose ack is showing still presents stale inputs this cycle.
    assign elig    = req & ~ack;
    assign np_req  = req & ~PRIO_BIT;
    assign np_elig = elig & ~PRIO_BIT;

    dendy_rr_pick #(.N(CH), .PW(PW)) u_pick_all (
        .mask(elig), .start(rr_ptr), .grant(g_all), .valid(v_all)
    );

    dendy_rr_pick #(.N(CH), .PW(PW)) u_pick_np (
        .mask(np_elig), .start(rr_ptr), .grant(g_np), .valid(v_np)
    );

    // A requesting PRIO channel keeps the slot even while its own ack blocks it.
    always_comb begin
        win    = '0;
        use_rr = 1'b0;
        if (starve_cnt == 4'(STARVE) && v_np) begin
            win    = g_np;
            use_rr = 1'b1;
        end else if (|(req & PRIO_BIT)) begin
            if (!(|(ack & PRIO_BIT))) win = PRIO_BIT;
        end else if (v_all) begin
            win    = g_all;
            use_rr = 1'b1;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        ptr_nxt   = rr_ptr;
        for (int i = 0; i < CH; i++) begin
            if (win[i]) begin
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
                sel_we    = we[i];
                ptr_nxt   = PW'((i + 1) % CH);
            end
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (|(win & ~PRIO_BIT) || !(|np_req))
            starve_nxt = '0;
        else if (|(win & PRIO_BIT) && starve_cnt != 4'(STARVE))
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack        <= '0;
            mem_a      <= '0;
            mem_o      <= '0;
            mem_w      <= 1'b0;
            rr_ptr     <= '0;
            starve_cnt <= '0;
            rd_tag_p0  <= '0;
            rd_tag_p1  <= '0;
            rvalid     <= '0;
            rdata      <= '0;
        end else begin
            // p0: grant registered, RAM address/strobe driven
            ack        <= win;
            mem_w      <= (|win) & sel_we;
            if (|win) begin
                mem_a <= sel_addr;
                mem_o <= sel_wdata;
            end
            if (use_rr) rr_ptr <= ptr_nxt;
            starve_cnt <= starve_nxt;
            rd_tag_p0  <= sel_we ? '0 : win;
            // p1: RAM captures mem_a
            rd_tag_p1  <= rd_tag_p0;
            // p2: RAM output registered with its owner tag
            rvalid     <= rd_tag_p1;
            if (|rd_tag_p1) rdata <= mem_i;
        end
    end

endmodule

// File: tb/tb_dendy_mem_arbiter.sv
// Directed bench for dendy_mem_arbiter with a registered single-port RAM model,
// a vector table for arbitration order and hand sequences for corner cases.
module tb_dendy_mem_arbiter;

    localparam int CH = 4;
    localparam int AW = 15;
    localparam int DW = 8;

    logic            clock;
    logic            reset;
    logic [CH-1:0]   req;
    logic [CH-1:0]   we;
    logic [CH*AW-1:0] addr;
    logic [CH*DW-1:0] wdata;
    logic [CH-1:0]   ack;
    logic [DW-1:0]   rdata;
    logic [CH-1:0]   rvalid;
    logic [AW-1:0]   mem_a;
    logic [DW-1:0]   mem_o;
    logic            mem_w;
    logic [DW-1:0]   mem_i;

    logic [DW-1:0]   ram [0:(1<<AW)-1];
    logic            pre_en;
    logic [AW-1:0]   pre_a;
    logic [DW-1:0]   pre_d;

    int n_vec;
    int n_bad;
    int cyc;

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [3:0]  ack;
        logic [3:0]  rv;
        logic [7:0]  rd;
    } vec_t;

    typedef struct {
        logic [3:0] own;
        logic [7:0] dat;
        int         due;
    } exp_t;

    localparam int NV = 21;
    vec_t vt [NV];
    exp_t q[$];

    dendy_mem_arbiter #(
        .CH(CH), .AW(AW), .DW(DW), .PRIO_CH(0), .STARVE(3)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .ack(ack), .rdata(rdata), .rvalid(rvalid),
        .mem_a(mem_a), .mem_o(mem_o), .mem_w(mem_w), .mem_i(mem_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Registered RAM: read data appears one cycle after the address.
    always @(posedge clock) begin
        if (pre_en) ram[pre_a] <= pre_d;
        else if (mem_w) ram[mem_a] <= mem_o;
        mem_i <= ram[mem_a];
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        we    = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},    32'(ack),    32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, "_rdata"},  32'(rdata),  32'h0);
        chk({tag, "_mem_a"},  32'(mem_a),  32'h0);
        chk({tag, "_mem_o"},  32'(mem_o),  32'h0);
        chk({tag, "_mem_w"},  32'(mem_w),  32'h0);
    endtask

    initial begin
        int idx0, idx2, got;
        n_vec  = 0;
        n_bad  = 0;
        cyc    = 0;
        reset  = 1'b1;
        req    = '0;
        we     = '0;
        addr   = '0;
        wdata  = '0;
        pre_en = 1'b0;
        pre_a  = '0;
        pre_d  = '0;

        // RR rows (ch1..ch3 continuous, ch0 idle), then PRIO/starvation rows.
        vt[0]  = '{1'b1, 4'b1110, 4'b0010, 4'b0000, 8'h00};
        vt[1]  = '{1'b0, 4'b1110, 4'b0100, 4'b0000, 8'h00};
        vt[2]  = '{1'b0, 4'b1110, 4'b1000, 4'b0010, 8'hC1};
        vt[3]  = '{1'b0, 4'b1110, 4'b0010, 4'b0100, 8'hC2};
        vt[4]  = '{1'b0, 4'b1110, 4'b0100, 4'b1000, 8'hC3};
        vt[5]  = '{1'b0, 4'b1110, 4'b1000, 4'b0010, 8'hC1};
        vt[6]  = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 8'hC2};
        vt[7]  = '{1'b0, 4'b0000, 4'b0000, 4'b1000, 8'hC3};
        vt[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 8'h00};
        vt[9]  = '{1'b1, 4'b0101, 4'b0001, 4'b0000, 8'h00};
        vt[10] = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 8'h00};
        vt[11] = '{1'b0, 4'b0101, 4'b0001, 4'b0001, 8'hC0};
        vt[12] = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 8'h00};
        vt[13] = '{1'b0, 4'b0101, 4'b0001, 4'b0001, 8'hC0};
        vt[14] = '{1'b0, 4'b0101, 4'b0100, 4'b0000, 8'h00};
        vt[15] = '{1'b0, 4'b0101, 4'b0001, 4'b0001, 8'hC0};
        vt[16] = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 8'hC2};
        vt[17] = '{1'b0, 4'b0101, 4'b0001, 4'b0001, 8'hC0};
        vt[18] = '{1'b0, 4'b0101, 4'b0000, 4'b0000, 8'h00};
        vt[19] = '{1'b0, 4'b0101, 4'b0001, 4'b0001, 8'hC0};
        vt[20] = '{1'b0, 4'b0101, 4'b0100, 4'b0000, 8'h00};

        preload(15'h2005, 8'hA7);
        for (int i = 0; i < 8; i++) preload(15'(16 + i), 8'(8'hC0 + i));
        chk_all_zero("reset");
        reset = 1'b0;

        // Single read on ch2
        addr[2*AW +: AW] = 15'h2005;
        req = 4'b0100;
        tick();
        chk("rd_ack",   32'(ack),   32'h4);
        chk("rd_mem_a", 32'(mem_a), 32'h2005);
        chk("rd_mem_w", 32'(mem_w), 32'h0);
        req = '0;
        tick();
        chk("rd_early_rvalid", 32'(rvalid), 32'h0);
        chk("rd_ack_pulse",    32'(ack),    32'h0);
        tick();
        chk("rd_rvalid", 32'(rvalid), 32'h4);
        chk("rd_rdata",  32'(rdata),  32'hA7);

        // Write on ch1, then read back on ch3
        addr[1*AW +: AW]  = 15'h0100;
        wdata[1*DW +: DW] = 8'h3C;
        we  = 4'b0010;
        req = 4'b0010;
        tick();
        chk("wr_ack",   32'(ack),   32'h2);
        chk("wr_mem_w", 32'(mem_w), 32'h1);
        chk("wr_mem_a", 32'(mem_a), 32'h0100);
        chk("wr_mem_o", 32'(mem_o), 32'h3C);
        req = '0;
        we  = '0;
        tick();
        chk("wr_mem_w_drop", 32'(mem_w),  32'h0);
        chk("wr_no_rvalid1", 32'(rvalid), 32'h0);
        tick();
        chk("wr_no_rvalid2", 32'(rvalid), 32'h0);
        addr[3*AW +: AW] = 15'h0100;
        req = 4'b1000;
        tick();
        chk("rb_ack", 32'(ack), 32'h8);
        req = '0;
        tick();
        tick();
        chk("rb_rvalid", 32'(rvalid), 32'h8);
        chk("rb_rdata",  32'(rdata),  32'h3C);

        // Reset while a read is in the pipeline
        addr[2*AW +: AW] = 15'h0014;
        req = 4'b0100;
        tick();
        chk("rst_ack", 32'(ack), 32'h4);
        req = '0;
        tick();
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        tick();
        chk_all_zero("rst_hold");
        tick();
        reset = 1'b0;
        tick();
        chk("rst_no_rvalid1", 32'(rvalid), 32'h0);
        tick();
        chk("rst_no_rvalid2", 32'(rvalid), 32'h0);
        addr[3*AW +: AW] = 15'h0015;
        req = 4'b1000;
        tick();
        chk("rst_resume_ack", 32'(ack), 32'h8);
        req = '0;
        tick();
        tick();
        chk("rst_resume_rvalid", 32'(rvalid), 32'h8);
        chk("rst_resume_rdata",  32'(rdata),  32'hC5);

        // Interleaved reads on ch0 (even addresses) and ch2 (odd addresses)
        do_reset();
        idx0 = 0;
        idx2 = 0;
        got  = 0;
        addr[0*AW +: AW] = 15'h0010;
        addr[2*AW +: AW] = 15'h0011;
        req = 4'b0101;
        for (int c = 0; c < 60 && got < 8; c++) begin
            tick();
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("mix_rvalid", 32'(rvalid), 32'(q[0].own));
                chk("mix_rdata",  32'(rdata),  32'(q[0].dat));
                void'(q.pop_front());
                got++;
            end else if (rvalid != '0) begin
                chk("mix_spurious_rvalid", 32'(rvalid), 32'h0);
            end
            if (ack[0]) begin
                q.push_back('{4'b0001, 8'(8'hC0 + 2*idx0), cyc + 2});
                idx0++;
                if (idx0 == 4) req[0] = 1'b0;
                else addr[0*AW +: AW] = 15'(16 + 2*idx0);
            end
            if (ack[2]) begin
                q.push_back('{4'b0100, 8'(8'hC1 + 2*idx2), cyc + 2});
                idx2++;
                if (idx2 == 4) req[2] = 1'b0;
                else addr[2*AW +: AW] = 15'(17 + 2*idx2);
            end
        end
        chk("mix_reads_returned", 32'(got), 32'd8);

        // Table: round-robin order and starvation guard
        addr[0*AW +: AW] = 15'h0010;
        addr[1*AW +: AW] = 15'h0011;
        addr[2*AW +: AW] = 15'h0012;
        addr[3*AW +: AW] = 15'h0013;
        for (int r = 0; r < NV; r++) begin
            if (vt[r].rst) do_reset();
            req = vt[r].req;
            we  = '0;
            tick();
            chk($sformatf("tbl%0d_ack", r),    32'(ack),    32'(vt[r].ack));
            chk($sformatf("tbl%0d_rvalid", r), 32'(rvalid), 32'(vt[r].rv));
            if (vt[r].rv != '0)
                chk($sformatf("tbl%0d_rdata", r), 32'(rdata), 32'(vt[r].rd));
        end
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dendy_mem_arbiter.md
Name: dendy_mem_arbiter

Overview:
- Parametrised N-channel arbiter that time-shares one single-port synchronous RAM among several requesters, such as PPU CHR/nametable fetch, OAM DMA, CPU PRG access and a debug port.
- Replaces the per-requester dedicated memory arrays of the current system level with one shared RAM.
- Provides fixed-priority plus round-robin arbitration, a starvation guard, and pipelined reads at one grant per clock.

Parameters:
- CH, 4: number of requester channels (2..8).
- AW, 15: address width.
- DW, 8: data width.
- PRIO_CH, 0: channel with fixed top priority (PPU video fetch); PRIO_CH = CH disables fixed priority.
- STARVE, 3: maximum consecutive PRIO_CH grants while any other channel is requesting (1..15).

Ports:
- clock  in  1  system clock, all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  CH  per-channel request level
- we  in  CH  per-channel write enable, valid with req
- addr  in  CH*AW  flattened addresses; channel i occupies [i*AW +: AW]
- wdata  in  CH*DW  flattened write data
- ack  out  CH  one-hot grant pulse, one cycle
- rdata  out  DW  read data, shared by all channels
- rvalid  out  CH  one-hot pulse: rdata belongs to this channel
- mem_a  out  AW  RAM address
- mem_o  out  DW  RAM write data
- mem_w  out  1  RAM write strobe
- mem_i  in  DW  RAM read data; registered in the RAM, valid one cycle after mem_a

Behaviour:
- Reset values: ack=0, rvalid=0, rdata=0, mem_a=0, mem_o=0, mem_w=0, rr pointer=0, starve counter=0, read pipeline cleared.
- Grant, edge E0:
  - Arbiter samples req and picks at most one winner w.
  - Registers mem_a=addr[w], mem_o=wdata[w], mem_w=we[w], ack=onehot(w).
  - All of these are visible in the cycle after E0.
- Winner selection order:
  - (a) If the starve counter equals STARVE and any non-PRIO channel is requesting: round-robin among the non-PRIO channels.
  - (b) Else, if req[PRIO_CH]: PRIO_CH wins.
  - (c) Else: round-robin over all channels.
- Round-robin search starts at the rr pointer. After any round-robin grant, the pointer becomes (w+1) mod CH. A PRIO grant leaves the pointer unchanged.
- Starve counter:
  - Increments on a PRIO grant while another channel is requesting.
  - Clears on any non-PRIO grant, or when no other channel is requesting.
  - Saturates at STARVE.
- No requests: ack=0, mem_w=0, mem_a holds its previous value.
- Reads:
  - Edge E1: RAM captures mem_a.
  - Edge E2: rdata<=mem_i and rvalid<=onehot(w) are registered.
  - Latency is 2 cycles from the ack pulse. A channel-tag shift register of depth 2 tracks the owner.
- Writes: mem_w is high for exactly the cycle after E0. No rvalid is generated.
- Throughput and handshake:
  - One grant per cycle. Back-to-back grants to the same channel are allowed.
  - A requester keeps req, addr, we and wdata stable until it sees ack, then updates them or drops req in that same cycle.
  - The arbiter never grants a channel in the cycle its ack is high. This prevents a duplicate grant on stale inputs, so a single continuous requester gets at most one grant every 2 cycles.
- Simultaneous events: an ack for one channel and an rvalid for another in the same cycle is legal and common.
- Reset mid-operation: in-flight reads are discarded with no rvalid. A write already registered may or may not reach the RAM.
- Width rules: addresses pass through unchanged. rr pointer is clog2(CH) bits; starve counter is 4 bits.

Decomposition:
- dendy_pkg holds:
  - default DW/AW constants;
  - channel index constants CH_PPU=0, CH_OAM=1, CH_CPU=2, CH_DBG=3;
  - a clog2-based width helper.
- One sub-module, dendy_rr_pick: combinational rotate, priority-encode and un-rotate.
  - Inputs: request mask and start pointer.
  - Outputs: one-hot winner and valid.
  - Used twice: once for the all-channel round-robin, once for the non-PRIO round-robin.

Test Plan:
- Single read: preload RAM[0x2005]=0xA7; ch2 req, we=0, addr=0x2005.
  - Required: ack[2] one cycle; two cycles later rvalid=0100, rdata=0xA7.
- Write then read: ch1 writes 0x3C to 0x0100.
  - Required: mem_w high one cycle with mem_a=0x0100, no rvalid.
  - A following ch3 read of 0x0100 returns 0x3C.
- Round-robin: ch1, ch2 and ch3 held requesting with PRIO disabled.
  - Required: grants 1,2,3,1,2,3 (gaps allowed per the handshake rule); rvalid order matches grant order.
- Priority and starvation: ch0 and ch2 requesting continuously, STARVE=3.
  - Required: every fourth grant goes to ch2, never more than 3 consecutive ch0 grants.
- Pipelined mixed traffic: interleaved reads on ch0 and ch2 to addresses 0x10..0x17.
  - Required: each rvalid carries the correct owner bit and the data at that address; no read is lost or duplicated.
- Reset mid-read: assert reset one cycle after ack of a read.
  - Required: no rvalid ever appears for it; all outputs are 0 while reset is high; normal grants resume after release.
